word_struct_assembler: RTL

- Inverse of the record-to-word split: collects NWORDS beats of WIDTH bits from a valid/ready stream and assembles them into one packed record (lane array [NWORDS-1:0][WIDTH-1:0]).
- Lane order: the first beat lands in the highest lane, so a record sent as 9, 12, 21 equals the packed pattern of those three words.
- A short record is closed early by in_last; unwritten lanes take FILL, like a default-filled pattern.
- Sits between a 64-bit word bus and consumers of p::S-style packed records.

---
 rtl/word_struct_assembler_pkg.sv | 18 +
 rtl/word_struct_assembler.sv | 92 +++++++++
 2 files changed

// File: rtl/word_struct_assembler_pkg.sv
// Shared types for the word-to-record assembler: lane and record layouts plus FSM states.
package word_struct_assembler_pkg;

  localparam int unsigned LANE_W    = 64;
  localparam int unsigned REC_WORDS = 3;

  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    lane_t [REC_WORDS-1:0] a;
  } rec_t;

  typedef enum logic {
    COLLECT,
    HOLD
  } state_e;

endpackage

// File: rtl/word_struct_assembler.sv
// Collects NWORDS valid/ready beats into one packed record; first beat lands in the top lane,
// in_last closes a record early and unwritten lanes take FILL.
module word_struct_assembler
  import word_struct_assembler_pkg::*;
#(
  parameter int unsigned      NWORDS = REC_WORDS,
  parameter int unsigned      WIDTH  = LANE_W,
  parameter logic [WIDTH-1:0] FILL   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NWORDS*WIDTH-1:0]      out_data,
  output logic [$clog2(NWORDS+1)-1:0]  out_count,
  output logic                         out_short
);

  localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned CW = $clog2(NWORDS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  state_e                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [NWORDS-1:0][WIDTH-1:0]   data_q, data_d;
  logic [CW-1:0]                  count_q, count_d;
  logic                           short_q, short_d;
  logic                           accept;
  logic                           complete;

  assign out_valid = (state_q == HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_short = short_q;

  // Consume and first-lane write may share an edge; a completing beat then re-enters HOLD.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    count_d  = count_q;
    short_d  = short_q;
    complete = 1'b0;

    if (out_valid && out_ready) begin
      state_d = COLLECT;
    end

    if (accept) begin
      for (int unsigned k = 0; k < NWORDS; k++) begin
        if (k + 32'(idx_q) == NWORDS - 1) begin
          data_d[k] = in_data;
        end else if (idx_q == '0) begin
          data_d[k] = FILL;
        end
      end

      complete = (idx_q == LAST_IDX) || in_last;
      if (complete) begin
        state_d = HOLD;
        idx_d   = '0;
        count_d = CW'(idx_q) + CW'(1);
        short_d = in_last && (idx_q != LAST_IDX);
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      data_q  <= {NWORDS{FILL}};
      count_q <= '0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      count_q <= count_d;
      short_q <= short_d;
    end
  end

endmodule
